// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: issue/flush inputs and stall/result outputs of the HI/LO sequencer
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
  logic             start_i;
  logic             is_div_i;
  logic             is_signed_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             flush_i;
  logic             stall_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  modport master (
    output start_i, is_div_i, is_signed_i, a_i, b_i, flush_i,
    input  stall_o, busy_o, done_o, hi_o, lo_o
  );
  modport slave (
    input  start_i, is_div_i, is_signed_i, a_i, b_i, flush_i,
    output stall_o, busy_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MULT/MULTU/DIV/DIVU sequencer producing {hi,lo} for the HI/LO write
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  muldiv_sequencer_if.slave    bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_div;
  logic               r_signed;
  logic               r_sq;
  logic               r_sr;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH:0]     w_sh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_quo;
  logic [2*WIDTH-1:0] w_ax;
  logic [2*WIDTH-1:0] w_bx;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_issue;
  // r_a doubles as multiplicand and as the divide's quotient shift register
  always_comb begin
    w_sh   = {r_rem, r_a[WIDTH-1]};
    w_ge   = w_sh >= {1'b0, r_b};
    w_rem  = w_ge ? WIDTH'(w_sh - {1'b0, r_b}) : w_sh[WIDTH-1:0];
    w_quo  = {r_a[WIDTH-2:0], w_ge};
    w_ax   = r_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
    w_bx   = r_signed ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
    w_prod = w_ax * w_bx;
  end
  assign w_issue     = (r_state == IDLE) && bus.start_i && !bus.flush_i;
  assign bus.stall_o = w_issue || (r_state == BUSY);
  assign bus.busy_o  = r_state != IDLE;
  assign bus.done_o  = r_state == DONE;
  assign bus.hi_o    = r_hi;
  assign bus.lo_o    = r_lo;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_div    <= 1'b0;
      r_signed <= 1'b0;
      r_sq     <= 1'b0;
      r_sr     <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_issue) begin
          r_state  <= BUSY;
          r_cnt    <= bus.is_div_i ? CW'(WIDTH) : CW'(1);
          r_div    <= bus.is_div_i;
          r_signed <= bus.is_signed_i;
          r_sq     <= bus.is_signed_i && (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);
          r_sr     <= bus.is_signed_i && bus.a_i[WIDTH-1];
          r_a      <= (bus.is_div_i && bus.is_signed_i && bus.a_i[WIDTH-1]) ? -bus.a_i : bus.a_i;
          r_b      <= (bus.is_div_i && bus.is_signed_i && bus.b_i[WIDTH-1]) ? -bus.b_i : bus.b_i;
          r_rem    <= '0;
        end
        BUSY: if (bus.flush_i) begin
          r_state <= IDLE;
        end else begin
          r_cnt <= r_cnt - CW'(1);
          if (r_div) begin
            r_rem <= w_rem;
            r_a   <= w_quo;
          end
          if (r_cnt == CW'(1)) begin
            r_state <= DONE;
            r_hi    <= r_div ? (r_sr ? -w_rem : w_rem) : w_prod[2*WIDTH-1:WIDTH];
            r_lo    <= r_div ? (r_sq ? -w_quo : w_quo) : w_prod[WIDTH-1:0];
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and random MULT/DIV checks against an arithmetic reference model
module tb_muldiv_sequencer;
  localparam int W = 32;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int n_tot = 0;
  int n_bad = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;
  muldiv_sequencer_if #(.WIDTH(W)) bus ();
  muldiv_sequencer #(.WIDTH(W)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // {hi,lo} from plain arithmetic: magnitudes, then sign rules
  function automatic logic [63:0] model(input logic dv, input logic sg, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] ua, ub, q, r;
    longint sa, sb;
    if (!dv) begin
      if (sg) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
      end
      return {32'b0, a} * {32'b0, b};
    end
    ua = (sg && a[W-1]) ? -a : a;
    ub = (sg && b[W-1]) ? -b : b;
    if (ub == 0) begin
      q = '1;
      r = ua;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    if (sg && (a[W-1] ^ b[W-1])) q = -q;
    if (sg && a[W-1]) r = -r;
    return {r, q};
  endfunction
  task automatic check_outputs_zero(input string tag);
    chk({tag, "_hi"}, bus.hi_o, 0);
    chk({tag, "_lo"}, bus.lo_o, 0);
    chk({tag, "_done"}, bus.done_o, 0);
    chk({tag, "_busy"}, bus.busy_o, 0);
    chk({tag, "_stall"}, bus.stall_o, 0);
  endtask
  task automatic run_op(input string tag, input logic dv, input logic sg, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat, k, gaps;
    logic [63:0] e;
    lat = dv ? W + 1 : 2;
    k = 0;
    gaps = 0;
    e = model(dv, sg, a, b);
    bus.start_i = 1'b1;
    bus.is_div_i = dv;
    bus.is_signed_i = sg;
    bus.a_i = a;
    bus.b_i = b;
    #1;
    chk({tag, "_stall_issue"}, bus.stall_o, 1);
    do begin
      @(posedge clk);
      #1;
      k++;
      if (!bus.done_o && !bus.stall_o) gaps++;
    end while (!bus.done_o && k < 60);
    chk({tag, "_latency"}, k, lat);
    chk({tag, "_stall_busy"}, gaps, 0);
    chk({tag, "_stall_done"}, bus.stall_o, 0);
    chk({tag, "_hi"}, bus.hi_o, e[63:32]);
    chk({tag, "_lo"}, bus.lo_o, e[31:0]);
    exp_hi = e[63:32];
    exp_lo = e[31:0];
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, bus.done_o, 0);
    chk({tag, "_idle"}, bus.busy_o, 0);
  endtask
  initial begin
    int dones;
    logic [W-1:0] ra, rb;
    logic dv, sg;
    bus.start_i = 1'b0;
    bus.is_div_i = 1'b0;
    bus.is_signed_i = 1'b0;
    bus.a_i = '0;
    bus.b_i = '0;
    bus.flush_i = 1'b0;
    #12;
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    run_op("divu_100_7", 1'b1, 1'b0, 32'd100, 32'd7);
    run_op("div_m7_2", 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2);
    run_op("div_7_m2", 1'b1, 1'b1, 32'd7, 32'hFFFFFFFE);
    run_op("mult_m1_2", 1'b0, 1'b1, 32'hFFFFFFFF, 32'd2);
    run_op("multu_ff_2", 1'b0, 1'b0, 32'hFFFFFFFF, 32'd2);
    run_op("divu_by0", 1'b1, 1'b0, 32'h1234, 32'd0);
    run_op("div_m5_by0", 1'b1, 1'b1, 32'hFFFFFFFB, 32'd0);
    run_op("div_min_m1", 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    // flush mid-divide: back to idle, no completion, results held
    bus.start_i = 1'b1;
    bus.is_div_i = 1'b1;
    bus.is_signed_i = 1'b1;
    bus.a_i = 32'd1000;
    bus.b_i = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    bus.start_i = 1'b0;
    #1;
    chk("flush_busy", bus.busy_o, 0);
    chk("flush_stall", bus.stall_o, 0);
    chk("flush_hi", bus.hi_o, exp_hi);
    chk("flush_lo", bus.lo_o, exp_lo);
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done_o) dones++;
    end
    chk("flush_no_done", dones, 0);
    // async reset mid-divide
    bus.start_i = 1'b1;
    bus.is_div_i = 1'b1;
    bus.is_signed_i = 1'b0;
    bus.a_i = 32'd999;
    bus.b_i = 32'd4;
    repeat (5) @(posedge clk);
    #2;
    bus.start_i = 1'b0;
    resetn = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    run_op("multu_3_5", 1'b0, 1'b0, 32'd3, 32'd5);
    for (int i = 0; i < 30; i++) begin
      dv = 1'($urandom % 2);
      sg = 1'($urandom % 2);
      ra = $urandom;
      case ($urandom % 4)
        0: rb = '0;
        1: rb = $urandom_range(1, 15);
        2: rb = -($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), dv, sg, ra, rb);
    end
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
